// File: rtl/xge_pkt_loopback_pkg.sv
// Shared definitions for the xge packet loopback bridge.
// Holds the skid FIFO entry layout and the framing FSM state type.
package xge_pkt_loopback_pkg;

  // FIFO entry layout: {data[63:0], sop, eop, mod[2:0]}
  localparam int unsigned EntryW  = 69;
  localparam int unsigned DataW   = 64;
  localparam int unsigned ModW    = 3;
  localparam int unsigned ModLsb  = 0;
  localparam int unsigned EopBit  = 3;
  localparam int unsigned SopBit  = 4;
  localparam int unsigned DataLsb = 5;

  typedef enum logic {
    StIdle    = 1'b0,
    StInFrame = 1'b1
  } frame_state_e;

endpackage

// File: rtl/xge_skid_fifo.sv
// Register-based skid FIFO with show-ahead read data.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, wdata - write strobe and entry
//   pop, rdata  - read strobe and head entry (valid when !empty)
//   empty       - no entries stored
//   occupancy   - number of stored entries (0..2**FIFO_AW)
module xge_skid_fifo
  import xge_pkt_loopback_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [EntryW-1:0] wdata,
  input  logic              pop,
  output logic [EntryW-1:0] rdata,
  output logic              empty,
  output logic [FIFO_AW:0]  occupancy
);

  localparam int unsigned Depth = 2 ** FIFO_AW;

  logic [EntryW-1:0]  mem_q [Depth];
  logic [FIFO_AW-1:0] wptr_q, rptr_q;
  logic [FIFO_AW:0]   count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (!push && pop) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only read behind a valid count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= wdata;
  end

  assign rdata     = mem_q[rptr_q];
  assign empty     = (count_q == '0);
  assign occupancy = count_q;

endmodule

// File: rtl/xge_pkt_loopback.sv
// Packet-interface loopback: reads frames from the xge_mac RX packet
// interface and replays them word-for-word on the TX packet interface.
// Ports:
//   clk_156m25, reset_156m25_n - core clock, async active-low reset
//   ctrl_enable, stat_clr      - start-new-frames enable, counter clear
//   pkt_rx_*                   - MAC receive packet interface
//   pkt_tx_*                   - MAC transmit packet interface
//   stat_*                     - saturating frame/error/violation counters
//   busy                       - frame in progress, data buffered or read pending
module xge_pkt_loopback
  import xge_pkt_loopback_pkg::*;
#(
  parameter int unsigned FIFO_AW = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25_n,
  input  logic             ctrl_enable,
  input  logic             stat_clr,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic             pkt_rx_val,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  input  logic             pkt_tx_full,
  output logic             pkt_tx_val,
  output logic [63:0]      pkt_tx_data,
  output logic             pkt_tx_sop,
  output logic             pkt_tx_eop,
  output logic [2:0]       pkt_tx_mod,
  output logic [CNT_W-1:0] stat_frames,
  output logic [CNT_W-1:0] stat_err_frames,
  output logic [CNT_W-1:0] stat_proto_err,
  output logic             busy
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  typedef logic [FIFO_AW+1:0] used_t;
  // A new read may issue only while stored + pending words leave two free slots:
  // one for the word returning now and one for the word this read will return.
  localparam used_t UsedMax = used_t'(Depth - 2);

  frame_state_e state_q, state_d;
  logic         wr_en, proto_err;
  logic         ren_q, ren_d;

  logic [EntryW-1:0] wr_entry, fifo_head, tx_entry;
  logic              fifo_empty, fifo_push, fifo_pop;
  logic [FIFO_AW:0]  occupancy;
  logic              tx_take;
  used_t             used;

  logic             tx_val_q, tx_sop_q, tx_eop_q;
  logic [63:0]      tx_data_q;
  logic [2:0]       tx_mod_q;
  logic [CNT_W-1:0] frames_q, err_frames_q, proto_q;

  // ---------------- Framing FSM ----------------
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) state_q <= StIdle;
    else                 state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (pkt_rx_val) begin
      unique case (state_q)
        StIdle:    if (pkt_rx_sop) state_d = pkt_rx_eop ? StIdle : StInFrame;
        // A stray sop restarts the frame, so only eop decides the next state.
        StInFrame: state_d = pkt_rx_eop ? StIdle : StInFrame;
        default:   state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    wr_en     = 1'b0;
    proto_err = 1'b0;
    if (pkt_rx_val) begin
      unique case (state_q)
        StIdle: begin
          wr_en     = pkt_rx_sop;
          proto_err = !pkt_rx_sop;
        end
        StInFrame: begin
          wr_en     = 1'b1;
          proto_err = pkt_rx_sop;
        end
        default: ;
      endcase
    end
  end

  // ---------------- Read request ----------------
  assign used  = {1'b0, occupancy} + {{(FIFO_AW + 1){1'b0}}, ren_q};
  assign ren_d = (((state_q == StIdle) && ctrl_enable && pkt_rx_avail) ||
                  (state_q == StInFrame)) && (used <= UsedMax);

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) ren_q <= 1'b0;
    else                 ren_q <= ren_d;
  end

  // ---------------- Skid FIFO with bypass ----------------
  assign wr_entry = {pkt_rx_data, pkt_rx_sop, pkt_rx_eop, pkt_rx_mod};

  // An incoming word goes straight to TX when nothing is queued ahead of it.
  assign tx_take   = (!fifo_empty || wr_en) && !pkt_tx_full;
  assign tx_entry  = fifo_empty ? wr_entry : fifo_head;
  assign fifo_push = wr_en && !(fifo_empty && tx_take);
  assign fifo_pop  = tx_take && !fifo_empty;

  xge_skid_fifo #(
    .FIFO_AW (FIFO_AW)
  ) u_fifo (
    .clk       (clk_156m25),
    .rst_n     (reset_156m25_n),
    .push      (fifo_push),
    .wdata     (wr_entry),
    .pop       (fifo_pop),
    .rdata     (fifo_head),
    .empty     (fifo_empty),
    .occupancy (occupancy)
  );

  // ---------------- TX register ----------------
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      tx_val_q  <= 1'b0;
      tx_data_q <= '0;
      tx_sop_q  <= 1'b0;
      tx_eop_q  <= 1'b0;
      tx_mod_q  <= '0;
    end else begin
      tx_val_q <= tx_take;
      if (tx_take) begin
        tx_data_q <= tx_entry[DataLsb +: DataW];
        tx_sop_q  <= tx_entry[SopBit];
        tx_eop_q  <= tx_entry[EopBit];
        tx_mod_q  <= tx_entry[ModLsb +: ModW];
      end
    end
  end

  // ---------------- Statistics ----------------
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      frames_q     <= '0;
      err_frames_q <= '0;
      proto_q      <= '0;
    end else if (stat_clr) begin
      frames_q     <= '0;
      err_frames_q <= '0;
      proto_q      <= '0;
    end else begin
      if (wr_en && pkt_rx_eop)               frames_q     <= sat_inc(frames_q);
      if (wr_en && pkt_rx_eop && pkt_rx_err) err_frames_q <= sat_inc(err_frames_q);
      if (proto_err)                         proto_q      <= sat_inc(proto_q);
    end
  end

  assign pkt_rx_ren      = ren_q;
  assign pkt_tx_val      = tx_val_q;
  assign pkt_tx_data     = tx_data_q;
  assign pkt_tx_sop      = tx_sop_q;
  assign pkt_tx_eop      = tx_eop_q;
  assign pkt_tx_mod      = tx_mod_q;
  assign stat_frames     = frames_q;
  assign stat_err_frames = err_frames_q;
  assign stat_proto_err  = proto_q;
  assign busy            = (state_q == StInFrame) || !fifo_empty || ren_q;

endmodule

// File: tb/tb_xge_pkt_loopback.sv
module tb_xge_pkt_loopback;

  localparam int unsigned FIFO_AW = 2;
  localparam int unsigned CNT_W   = 32;
  localparam int          DEPTH   = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ctrl_enable = 1'b1;
  logic             stat_clr = 1'b0;
  logic             pkt_rx_avail = 1'b0;
  logic             pkt_rx_ren;
  logic             pkt_rx_val = 1'b0;
  logic [63:0]      pkt_rx_data = '0;
  logic             pkt_rx_sop = 1'b0;
  logic             pkt_rx_eop = 1'b0;
  logic [2:0]       pkt_rx_mod = '0;
  logic             pkt_rx_err = 1'b0;
  logic             pkt_tx_full = 1'b0;
  logic             pkt_tx_val;
  logic [63:0]      pkt_tx_data;
  logic             pkt_tx_sop, pkt_tx_eop;
  logic [2:0]       pkt_tx_mod;
  logic [CNT_W-1:0] stat_frames, stat_err_frames, stat_proto_err;
  logic             busy;

  always #5 clk = ~clk;

  xge_pkt_loopback #(
    .FIFO_AW (FIFO_AW),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_156m25      (clk),
    .reset_156m25_n  (rst_n),
    .ctrl_enable     (ctrl_enable),
    .stat_clr        (stat_clr),
    .pkt_rx_avail    (pkt_rx_avail),
    .pkt_rx_ren      (pkt_rx_ren),
    .pkt_rx_val      (pkt_rx_val),
    .pkt_rx_data     (pkt_rx_data),
    .pkt_rx_sop      (pkt_rx_sop),
    .pkt_rx_eop      (pkt_rx_eop),
    .pkt_rx_mod      (pkt_rx_mod),
    .pkt_rx_err      (pkt_rx_err),
    .pkt_tx_full     (pkt_tx_full),
    .pkt_tx_val      (pkt_tx_val),
    .pkt_tx_data     (pkt_tx_data),
    .pkt_tx_sop      (pkt_tx_sop),
    .pkt_tx_eop      (pkt_tx_eop),
    .pkt_tx_mod      (pkt_tx_mod),
    .stat_frames     (stat_frames),
    .stat_err_frames (stat_err_frames),
    .stat_proto_err  (stat_proto_err),
    .busy            (busy)
  );

  // MAC-side frame store and expected TX stream
  typedef struct {
    logic [63:0] data;
    logic        sop, eop;
    logic [2:0]  mod;
    logic        err;
  } rx_word_t;

  typedef struct {
    logic [63:0] data;
    logic        sop, eop;
    logic [2:0]  mod;
    int          cyc;
  } tx_exp_t;

  typedef struct {
    int         nwords;
    logic [2:0] mod;
    logic       err;
    int         full_at;
    int         full_len;
    int         exp_frames;
    int         exp_err;
  } scen_t;

  rx_word_t mac_q[$];
  tx_exp_t  exp_q[$];

  int n_cmp = 0, n_fail = 0;
  int cyc = 0, ren_seen = 0;
  bit full_prev = 0, lat_chk = 0, clr_on_eop = 0;
  // reference model: inside-frame flag and counters
  bit m_in_frame = 0;
  int m_frames = 0, m_err = 0, m_proto = 0;

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctrl"}, 64'({pkt_rx_ren, pkt_tx_val, pkt_tx_sop, pkt_tx_eop,
                                   pkt_tx_mod, busy}), 64'd0);
    check_eq({tag, "_data"}, pkt_tx_data, 64'd0);
    check_eq({tag, "_cnt"}, {stat_frames, stat_err_frames}, 64'd0);
    check_eq({tag, "_proto"}, 64'(stat_proto_err), 64'd0);
  endtask

  // Spec framing rules applied to every word the MAC hands over.
  task automatic model_word(input rx_word_t w);
    tx_exp_t e;
    if (!m_in_frame && !w.sop) begin
      m_proto++;
    end else begin
      if (m_in_frame && w.sop) m_proto++;
      e.data = w.data; e.sop = w.sop; e.eop = w.eop; e.mod = w.mod; e.cyc = cyc;
      exp_q.push_back(e);
      if (w.eop) begin
        m_frames++;
        if (w.err) m_err++;
      end
      m_in_frame = !w.eop;
    end
  endtask

  task automatic push_word(input logic sop, input logic eop, input logic [2:0] mod,
                           input logic err);
    rx_word_t w;
    w.data = {$urandom, $urandom};
    w.sop = sop; w.eop = eop; w.mod = mod; w.err = err;
    mac_q.push_back(w);
    pkt_rx_avail = 1'b1;
  endtask

  task automatic push_frame(input int n, input logic [2:0] mod, input logic err);
    for (int i = 0; i < n; i++) begin
      push_word(i == 0, i == n - 1, (i == n - 1) ? mod : 3'($urandom),
                (i == n - 1) ? err : 1'($urandom));
    end
  endtask

  // One clock cycle: MAC answers last cycle's read, TX output is scored.
  task automatic tick();
    logic     ren_s;
    rx_word_t w;
    tx_exp_t  e;
    ren_s     = pkt_rx_ren;
    full_prev = pkt_tx_full;
    @(posedge clk);
    #1;
    cyc++;
    if (pkt_rx_ren) ren_seen++;
    if (pkt_tx_val) begin
      check_eq("tx_after_full", 64'(full_prev), 64'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL tx_unexpected: got word %h, expected no write", pkt_tx_data);
      end else begin
        e = exp_q.pop_front();
        check_eq("tx_data", pkt_tx_data, e.data);
        check_eq("tx_flags", 64'({pkt_tx_sop, pkt_tx_eop, pkt_tx_mod}),
                 64'({e.sop, e.eop, e.mod}));
        if (lat_chk) check_eq("tx_latency", 64'(cyc - e.cyc), 64'd1);
      end
    end
    check_eq("fifo_bound", 64'(exp_q.size() <= DEPTH), 64'd1);
    pkt_rx_val  = 1'b0;
    stat_clr    = 1'b0;
    pkt_rx_data = {$urandom, $urandom};
    pkt_rx_sop  = 1'($urandom);
    pkt_rx_eop  = 1'($urandom);
    pkt_rx_mod  = 3'($urandom);
    pkt_rx_err  = 1'($urandom);
    if (ren_s && mac_q.size() > 0) begin
      w = mac_q.pop_front();
      pkt_rx_val = 1'b1;
      pkt_rx_data = w.data; pkt_rx_sop = w.sop; pkt_rx_eop = w.eop;
      pkt_rx_mod = w.mod;   pkt_rx_err = w.err;
      model_word(w);
      if (clr_on_eop && w.eop) begin
        stat_clr = 1'b1;
        clr_on_eop = 0;
        m_frames = 0; m_err = 0; m_proto = 0;
      end
    end
    pkt_rx_avail = (mac_q.size() != 0);
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((busy || mac_q.size() != 0 || exp_q.size() != 0) && k < 300) begin
      tick();
      k++;
    end
    check_eq({name, "_drain"}, 64'(k < 300), 64'd1);
  endtask

  scen_t scen [5];

  initial begin
    int k;
    scen[0] = '{nwords: 3, mod: 3'd5, err: 1'b0, full_at: 0, full_len: 0,  exp_frames: 1, exp_err: 0};
    scen[1] = '{nwords: 8, mod: 3'd0, err: 1'b0, full_at: 3, full_len: 10, exp_frames: 2, exp_err: 0};
    scen[2] = '{nwords: 4, mod: 3'd2, err: 1'b1, full_at: 0, full_len: 0,  exp_frames: 3, exp_err: 1};
    scen[3] = '{nwords: 1, mod: 3'd7, err: 1'b0, full_at: 0, full_len: 0,  exp_frames: 4, exp_err: 1};
    scen[4] = '{nwords: 5, mod: 3'd1, err: 1'b1, full_at: 0, full_len: 4,  exp_frames: 5, exp_err: 2};

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed frames: sizes, mod, err and tx_full windows
    foreach (scen[s]) begin
      push_frame(scen[s].nwords, scen[s].mod, scen[s].err);
      lat_chk = (scen[s].full_len == 0);
      for (int c = 0; c < scen[s].nwords + scen[s].full_at + scen[s].full_len + 2; c++) begin
        pkt_tx_full = (c >= scen[s].full_at) && (c < scen[s].full_at + scen[s].full_len);
        tick();
      end
      pkt_tx_full = 1'b0;
      drain("scen");
      lat_chk = 0;
      check_eq("scen_frames", 64'(stat_frames), 64'(scen[s].exp_frames));
      check_eq("scen_err_frames", 64'(stat_err_frames), 64'(scen[s].exp_err));
      check_eq("scen_mod_hold", 64'(pkt_tx_mod), 64'(scen[s].mod));
      check_eq("scen_ren_idle", 64'(pkt_rx_ren), 64'd0);
    end
    check_eq("scen_proto", 64'(stat_proto_err), 64'd0);

    // Orphan word in idle, then a frame with a stray sop inside it
    push_word(1'b0, 1'b0, 3'd0, 1'b0);
    repeat (6) tick();
    check_eq("orphan_proto", 64'(stat_proto_err), 64'd1);
    check_eq("orphan_no_tx", 64'(exp_q.size()), 64'd0);
    push_word(1'b1, 1'b0, 3'd0, 1'b0);
    push_word(1'b0, 1'b0, 3'd0, 1'b0);
    push_word(1'b1, 1'b0, 3'd0, 1'b0);
    push_word(1'b0, 1'b0, 3'd0, 1'b0);
    push_word(1'b0, 1'b1, 3'd3, 1'b0);
    drain("restart");
    check_eq("restart_proto", 64'(stat_proto_err), 64'd2);
    check_eq("restart_frames", 64'(stat_frames), 64'd6);

    // Enable dropped mid-frame: frame completes, nothing new is read
    push_frame(6, 3'd4, 1'b0);
    repeat (4) tick();
    ctrl_enable = 1'b0;
    drain("disable");
    check_eq("disable_frames", 64'(stat_frames), 64'd7);
    push_frame(2, 3'd6, 1'b0);
    ren_seen = 0;
    repeat (20) tick();
    check_eq("disable_no_ren", 64'(ren_seen), 64'd0);
    ctrl_enable = 1'b1;
    drain("reenable");
    check_eq("reenable_frames", 64'(stat_frames), 64'd8);

    // Reset with words buffered behind tx_full
    push_frame(8, 3'd2, 1'b0);
    pkt_tx_full = 1'b1;
    k = 0;
    while (exp_q.size() < 3 && k < 30) begin
      tick();
      k++;
    end
    check_eq("buffered3", 64'(exp_q.size() >= 3), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    pkt_rx_val = 1'b0;
    pkt_tx_full = 1'b0;
    mac_q.delete();
    exp_q.delete();
    m_in_frame = 0; m_frames = 0; m_err = 0; m_proto = 0;
    pkt_rx_avail = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_reset_outputs("postreset");

    // stat_clr in the same cycle as an eop write
    clr_on_eop = 1;
    push_frame(2, 3'd1, 1'b1);
    drain("clr");
    check_eq("clr_frames", 64'(stat_frames), 64'd0);
    check_eq("clr_err_frames", 64'(stat_err_frames), 64'd0);
    check_eq("clr_proto", 64'(stat_proto_err), 64'd0);

    // Randomised traffic against the model
    for (int c = 0; c < 600; c++) begin
      if (mac_q.size() < 6) begin
        if ($urandom_range(0, 9) == 0) push_word(1'b0, 1'($urandom), 3'($urandom), 1'b0);
        k = $urandom_range(1, 6);
        for (int i = 0; i < k; i++) begin
          push_word((i == 0) || ($urandom_range(0, 11) == 0), i == k - 1,
                    3'($urandom), 1'($urandom));
        end
      end
      pkt_tx_full = ($urandom_range(0, 3) == 0);
      ctrl_enable = ($urandom_range(0, 9) != 0);
      tick();
    end
    ctrl_enable = 1'b1;
    pkt_tx_full = 1'b0;
    drain("rand");
    check_eq("rand_frames", 64'(stat_frames), 64'(m_frames));
    check_eq("rand_err_frames", 64'(stat_err_frames), 64'(m_err));
    check_eq("rand_proto", 64'(stat_proto_err), 64'(m_proto));
    check_eq("rand_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
